// File: rtl/sd_cmd_responder.sv
// SD card-side CMD line responder.
// Receives 48-bit host command frames (CRC7 checked). After a good frame it
// accepts one response request and drives it back on the CMD line: NCR
// idle-high cycles, then a 48-bit response frame with a generated CRC7.
module sd_cmd_responder #(
  parameter int unsigned NCR = 2  // idle-high cycles before the response (2..63)
) (
  input  logic        iclk,
  input  logic        irst,
  input  logic        icmd,
  output logic        ocmd,
  output logic        ocmd_oe,
  output logic        ocmd_valid,
  output logic [5:0]  ocmd_index,
  output logic [31:0] ocmd_arg,
  output logic        ocrc_err,
  output logic        oresp_ready,
  input  logic        iresp_valid,
  input  logic [5:0]  iresp_index,
  input  logic [31:0] iresp_arg,
  input  logic        iresp_nocrc,
  output logic        odone
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX,
    S_SKIP,
    S_WAIT_RESP,
    S_PRE,
    S_TX
  } state_e;

  localparam logic [5:0] NCR_LAST = 6'(NCR - 1);

  // Frame bit positions expressed as bit-counter values.
  localparam logic [5:0] CNT_TBIT     = 6'd1;   // transmission bit
  localparam logic [5:0] CNT_CRC_LAST = 6'd39;  // last bit covered by CRC7
  localparam logic [5:0] CNT_SKIP_END = 6'd45;  // last of the 46 skipped bits
  localparam logic [5:0] CNT_END      = 6'd47;  // end bit

  // One serial step of CRC7, polynomial x^7 + x^3 + 1.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    crc7_step = {crc[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
  endfunction

  state_e       state_q, state_d;
  logic [5:0]   cnt_q, cnt_d;
  logic [6:0]   crc_q, crc_d;
  logic [45:0]  rx_sh_q, rx_sh_d;     // frame bits 46..1; bit b lands in rx_sh[b-1]
  logic [47:0]  tx_sh_q, tx_sh_d;     // response frame, MSB is on the line
  logic         nocrc_q, nocrc_d;
  logic         cmd_valid_q, cmd_valid_d;
  logic         crc_err_q, crc_err_d;
  logic [5:0]   cmd_index_q, cmd_index_d;
  logic [31:0]  cmd_arg_q, cmd_arg_d;
  logic         done_q, done_d;
  logic         rx_err;

  // Next-state and datapath logic for receive, response wait, and transmit.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    crc_d       = crc_q;
    rx_sh_d     = rx_sh_q;
    tx_sh_d     = tx_sh_q;
    nocrc_d     = nocrc_q;
    cmd_index_d = cmd_index_q;
    cmd_arg_d   = cmd_arg_q;
    cmd_valid_d = 1'b0;
    crc_err_d   = 1'b0;
    done_d      = 1'b0;
    rx_err      = (crc_q != rx_sh_q[6:0]) | ~icmd;

    unique case (state_q)
      S_IDLE: begin
        if (!icmd) begin
          // The start bit is zero, so it leaves a zero CRC unchanged.
          state_d = S_RX;
          cnt_d   = 6'd1;
          crc_d   = '0;
          rx_sh_d = '0;
        end
      end

      S_RX: begin
        rx_sh_d = {rx_sh_q[44:0], icmd};
        cnt_d   = cnt_q + 6'd1;
        if (cnt_q <= CNT_CRC_LAST) crc_d = crc7_step(crc_q, icmd);
        if (cnt_q == CNT_TBIT && !icmd) begin
          // Card-to-host frame seen on the line: consume it silently.
          state_d = S_SKIP;
          cnt_d   = '0;
        end else if (cnt_q == CNT_END) begin
          cmd_valid_d = 1'b1;
          crc_err_d   = rx_err;
          cmd_index_d = rx_sh_q[44:39];
          cmd_arg_d   = rx_sh_q[38:7];
          state_d     = rx_err ? S_IDLE : S_WAIT_RESP;
          cnt_d       = '0;
        end
      end

      S_SKIP: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == CNT_SKIP_END) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end

      S_WAIT_RESP: begin
        // A response request wins over a simultaneous host start bit.
        if (iresp_valid) begin
          tx_sh_d = {2'b00, iresp_index, iresp_arg, 7'h7F, 1'b1};
          nocrc_d = iresp_nocrc;
          crc_d   = '0;
          cnt_d   = '0;
          state_d = S_PRE;
        end else if (!icmd) begin
          state_d = S_RX;
          cnt_d   = 6'd1;
          crc_d   = '0;
          rx_sh_d = '0;
        end
      end

      S_PRE: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == NCR_LAST) begin
          state_d = S_TX;
          cnt_d   = '0;
        end
      end

      S_TX: begin
        tx_sh_d = {tx_sh_q[46:0], 1'b1};
        cnt_d   = cnt_q + 6'd1;
        if (cnt_q <= CNT_CRC_LAST) crc_d = crc7_step(crc_q, tx_sh_q[47]);
        // After the 40th bit the preset 7'h7F field reaches the top; overwrite
        // it with the finished CRC unless the response asked for no CRC.
        if (cnt_q == CNT_CRC_LAST && !nocrc_q)
          tx_sh_d[47:41] = crc7_step(crc_q, tx_sh_q[47]);
        if (cnt_q == CNT_END) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and datapath registers; reset releases the line immediately.
  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      crc_q       <= '0;
      rx_sh_q     <= '0;
      tx_sh_q     <= '0;
      nocrc_q     <= 1'b0;
      cmd_valid_q <= 1'b0;
      crc_err_q   <= 1'b0;
      cmd_index_q <= '0;
      cmd_arg_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      crc_q       <= crc_d;
      rx_sh_q     <= rx_sh_d;
      tx_sh_q     <= tx_sh_d;
      nocrc_q     <= nocrc_d;
      cmd_valid_q <= cmd_valid_d;
      crc_err_q   <= crc_err_d;
      cmd_index_q <= cmd_index_d;
      cmd_arg_q   <= cmd_arg_d;
      done_q      <= done_d;
    end
  end

  // Line drive decodes straight from the state register, so an async reset
  // floats the pad in the same instant.
  assign ocmd_oe     = (state_q == S_PRE) || (state_q == S_TX);
  assign ocmd        = (state_q == S_TX) ? tx_sh_q[47] : 1'b1;
  assign oresp_ready = (state_q == S_WAIT_RESP);
  assign ocmd_valid  = cmd_valid_q;
  assign ocrc_err    = crc_err_q;
  assign ocmd_index  = cmd_index_q;
  assign ocmd_arg    = cmd_arg_q;
  assign odone       = done_q;

endmodule

// File: tb/tb_sd_cmd_responder.sv
// Directed bench for sd_cmd_responder: host frames are driven on icmd,
// expected command reports and response frames go into scoreboard queues,
// and a monitor pops and compares them as the DUT produces them.
module tb_sd_cmd_responder;

  localparam int unsigned NCR = 2;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic        err;
  } cmd_exp_t;

  logic        iclk = 1'b0;
  logic        irst;
  logic        icmd;
  logic        ocmd;
  logic        ocmd_oe;
  logic        ocmd_valid;
  logic [5:0]  ocmd_index;
  logic [31:0] ocmd_arg;
  logic        ocrc_err;
  logic        oresp_ready;
  logic        iresp_valid;
  logic [5:0]  iresp_index;
  logic [31:0] iresp_arg;
  logic        iresp_nocrc;
  logic        odone;

  int errors = 0;
  int checks = 0;

  cmd_exp_t    cmd_q[$];
  logic [47:0] resp_q[$];

  // Monitor state
  logic        prev_oe = 1'b0;
  logic        fell;
  int          oe_cnt  = 0;
  logic        pre_ok  = 1'b1;
  logic [47:0] cap     = '0;
  logic        abort   = 1'b0;

  sd_cmd_responder #(.NCR(NCR)) dut (
    .iclk        (iclk),
    .irst        (irst),
    .icmd        (icmd),
    .ocmd        (ocmd),
    .ocmd_oe     (ocmd_oe),
    .ocmd_valid  (ocmd_valid),
    .ocmd_index  (ocmd_index),
    .ocmd_arg    (ocmd_arg),
    .ocrc_err    (ocrc_err),
    .oresp_ready (oresp_ready),
    .iresp_valid (iresp_valid),
    .iresp_index (iresp_index),
    .iresp_arg   (iresp_arg),
    .iresp_nocrc (iresp_nocrc),
    .odone       (odone)
  );

  always #5 iclk = ~iclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference CRC7 (x^7 + x^3 + 1, init 0) over a 40-bit header.
  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [47:0] mk_frame(input logic tbit, input logic [5:0] idx,
                                           input logic [31:0] arg, input logic nocrc);
    logic [39:0] head;
    head = {1'b0, tbit, idx, arg};
    return {head, (nocrc ? 7'h7F : crc7(head)), 1'b1};
  endfunction

  task automatic send_bits(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) begin
      @(negedge iclk);
      icmd = f[i];
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge iclk);
      icmd = 1'b1;
    end
  endtask

  task automatic expect_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic err);
    cmd_exp_t e;
    e.idx = idx;
    e.arg = arg;
    e.err = err;
    cmd_q.push_back(e);
  endtask

  task automatic wait_ready(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge iclk);
      if (oresp_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("timeout_resp_ready", 0, 1);
  endtask

  task automatic respond(input logic [5:0] idx, input logic [31:0] arg,
                         input logic nocrc, input logic [47:0] exp_frame);
    logic ok;
    wait_ready(ok);
    if (ok) begin
      resp_q.push_back(exp_frame);
      iresp_valid = 1'b1;
      iresp_index = idx;
      iresp_arg   = arg;
      iresp_nocrc = nocrc;
      @(negedge iclk);
      // Junk after acceptance must not reach the transmitted frame.
      iresp_valid = 1'b0;
      iresp_index = ~idx;
      iresp_arg   = ~arg;
      iresp_nocrc = ~nocrc;
    end
  endtask

  task automatic wait_resp_done();
    for (int i = 0; i < 300; i++) begin
      if (resp_q.size() == 0) break;
      @(negedge iclk);
    end
    check("resp_drained", resp_q.size(), 0);
  endtask

  // Scoreboard monitor: command reports and response frames.
  always @(negedge iclk) begin
    if (irst) begin
      if (ocmd_valid) begin
        if (cmd_q.size() == 0) begin
          check("cmd_valid_unexpected", ocmd_valid, 0);
        end else begin
          cmd_exp_t e;
          e = cmd_q.pop_front();
          check("cmd_index", ocmd_index, e.idx);
          check("cmd_arg", ocmd_arg, e.arg);
          check("cmd_crc_err", ocrc_err, e.err);
          check("cmd_resp_ready", oresp_ready, !e.err);
        end
      end else if (ocrc_err) begin
        check("crc_err_outside_valid", ocrc_err, 0);
      end

      fell = prev_oe && !ocmd_oe;
      if (ocmd_oe) begin
        if (!prev_oe) check("oe_rise_expected", resp_q.size() > 0, 1);
        oe_cnt++;
        if (oe_cnt <= NCR) begin
          if (!ocmd) pre_ok = 1'b0;
        end else begin
          cap = {cap[46:0], ocmd};
        end
      end

      if (fell) begin
        if (abort) begin
          check("abort_no_done", odone, 0);
          abort = 1'b0;
        end else begin
          check("oe_cycles", oe_cnt, NCR + 48);
          check("pre_idle_high", pre_ok, 1);
          check("done_on_fall", odone, 1);
          check("line_high_after", ocmd, 1);
          if (resp_q.size() > 0) check("resp_frame", cap, resp_q.pop_front());
          else check("resp_frame_expected", 0, 1);
        end
        oe_cnt = 0;
        cap    = '0;
        pre_ok = 1'b1;
      end else if (odone) begin
        check("done_only_on_fall", odone, 0);
      end
      prev_oe = ocmd_oe;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        ok;
    logic [47:0] f;

    irst        = 1'b0;
    icmd        = 1'b1;
    iresp_valid = 1'b0;
    iresp_index = '0;
    iresp_arg   = '0;
    iresp_nocrc = 1'b0;

    // Reset state
    #23;
    check("rst_ocmd", ocmd, 1);
    check("rst_oe", ocmd_oe, 0);
    check("rst_valid", ocmd_valid, 0);
    check("rst_crc_err", ocrc_err, 0);
    check("rst_ready", oresp_ready, 0);
    check("rst_done", odone, 0);
    check("rst_index", ocmd_index, 0);
    check("rst_arg", ocmd_arg, 0);
    @(negedge iclk);
    irst = 1'b1;
    idle(2);

    // CMD0 good frame
    expect_cmd(6'd0, 32'h0, 1'b0);
    send_bits(48'h400000000095);
    idle(3);
    check("cmd0_reported", cmd_q.size(), 0);
    check("cmd0_wait_ready", oresp_ready, 1);

    // New host start bit while waiting for a response: CMD8 is received
    expect_cmd(6'd8, 32'h000001AA, 1'b0);
    send_bits(48'h48000001AA87);
    idle(3);
    check("cmd8_reported", cmd_q.size(), 0);
    respond(6'd8, 32'h000001AA, 1'b0, 48'h08000001AA13);
    wait_resp_done();

    // Bad CRC, then good CRC with end bit 0
    expect_cmd(6'd0, 32'h0, 1'b1);
    send_bits(48'h400000000097);
    idle(6);
    check("badcrc_reported", cmd_q.size(), 0);
    check("badcrc_no_ready", oresp_ready, 0);
    expect_cmd(6'd0, 32'h0, 1'b1);
    send_bits(48'h400000000094);
    idle(6);
    check("endbit0_reported", cmd_q.size(), 0);
    check("endbit0_no_ready", oresp_ready, 0);

    // R3-style response without CRC
    expect_cmd(6'd41, 32'h40FF8000, 1'b0);
    send_bits(mk_frame(1'b1, 6'd41, 32'h40FF8000, 1'b0));
    idle(3);
    respond(6'h3F, 32'h80FF8000, 1'b1, 48'h3F80FF8000FF);
    wait_resp_done();

    // CMD17 with a computed CRC, R1 response
    expect_cmd(6'd17, 32'h12345678, 1'b0);
    send_bits(mk_frame(1'b1, 6'd17, 32'h12345678, 1'b0));
    idle(3);
    respond(6'd17, 32'h00000900, 1'b0, mk_frame(1'b0, 6'd17, 32'h00000900, 1'b0));
    wait_resp_done();

    // Transmission bit 0: skipped; iresp_valid in IDLE ignored; next frame
    // follows back-to-back and must be received normally.
    send_bits(48'h000000000000);
    idle(2);
    iresp_valid = 1'b1;
    iresp_index = 6'd5;
    idle(3);
    iresp_valid = 1'b0;
    idle(4);
    check("skip_no_cmd", cmd_q.size(), 0);
    check("idle_resp_ignored_oe", ocmd_oe, 0);
    check("idle_resp_ignored_ready", oresp_ready, 0);
    send_bits(48'h000000000000);
    expect_cmd(6'd0, 32'h0, 1'b0);
    send_bits(48'h400000000095);
    idle(3);
    check("after_skip_cmd0", cmd_q.size(), 0);

    // Collision: response request and host start bit in the same cycle
    wait_ready(ok);
    if (ok) begin
      f = 48'h48000001AA87;
      resp_q.push_back(mk_frame(1'b0, 6'd1, 32'h00C0FFEE, 1'b0));
      iresp_valid = 1'b1;
      iresp_index = 6'd1;
      iresp_arg   = 32'h00C0FFEE;
      iresp_nocrc = 1'b0;
      icmd        = f[47];
      for (int i = 46; i >= 0; i--) begin
        @(negedge iclk);
        icmd        = f[i];
        iresp_valid = 1'b0;
      end
    end
    idle(2);
    wait_resp_done();
    idle(3);
    check("collision_cmd_ignored", cmd_q.size(), 0);
    check("collision_back_idle", oresp_ready, 0);

    // Reset 20 cycles into TX
    expect_cmd(6'd8, 32'h000001AA, 1'b0);
    send_bits(48'h48000001AA87);
    idle(3);
    respond(6'd8, 32'h000001AA, 1'b0, 48'h08000001AA13);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ocmd_oe) begin
        ok = 1'b1;
        break;
      end
      @(negedge iclk);
    end
    check("oe_rose_before_reset", ok, 1);
    repeat (NCR + 20) @(posedge iclk);
    #3;
    abort = 1'b1;
    resp_q.delete();
    irst  = 1'b0;
    #1;
    check("abort_oe", ocmd_oe, 0);
    check("abort_ocmd", ocmd, 1);
    check("abort_done", odone, 0);
    check("abort_index", ocmd_index, 0);
    check("abort_arg", ocmd_arg, 0);
    idle(3);
    irst = 1'b1;
    idle(3);
    check("abort_no_done_after", odone, 0);

    // Reception and response after reset
    expect_cmd(6'd0, 32'h0, 1'b0);
    send_bits(48'h400000000095);
    idle(3);
    check("post_reset_cmd0", cmd_q.size(), 0);
    respond(6'd1, 32'h00FF8000, 1'b0, mk_frame(1'b0, 6'd1, 32'h00FF8000, 1'b0));
    wait_resp_done();
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
